// File: rtl/counter_monitor_pkg.sv
//-----------------------------------------------------------------------------
// counter_monitor_pkg
//
// Shared definitions for the 32-bit up/down/load counter and its monitor:
//   - counter mode encodings (MODO input of the counter)
//   - monitor FSM state encodings (plain constants, legacy-compatible)
//   - data widths and the LOAD indication value
//   - the per-cycle sample the monitor keeps of the counter controls
//
// No ports; imported with `import counter_monitor_pkg::*;`.
//-----------------------------------------------------------------------------
package counter_monitor_pkg;

  // Datapath widths of the counter under check.
  localparam int CNT_W  = 32;
  localparam int LOAD_W = 8;

  // Value the counter drives on LOAD in the cycle after a load.
  localparam logic [LOAD_W-1:0] LOAD_ON  = 8'hFF;
  localparam logic [LOAD_W-1:0] LOAD_OFF = 8'h00;

  // Counter operating modes, as encoded on MODO.
  typedef enum logic [1:0] {
    COUNT_UP     = 2'b00,
    COUNT_DOWN   = 2'b01,
    COUNT_3_DOWN = 2'b10,
    CHARGE       = 2'b11
  } mode_e;

  // Monitor FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // One cycle's worth of counter controls plus the counter value, kept so
  // that the next cycle's outputs can be predicted from it.
  typedef struct packed {
    logic             en;
    mode_e            mode;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] q;
  } sample_t;

  localparam sample_t SAMPLE_RST = '{en: 1'b0, mode: COUNT_UP, d: '0, q: '0};

endpackage : counter_monitor_pkg

// File: rtl/counter_monitor_if.sv
//-----------------------------------------------------------------------------
// counter_monitor_if
//
// Signals exchanged between the 32-bit counter and anything observing it.
//   ENABLE  1        counter enable, as presented to the counter
//   MODO    2        counter mode (see counter_monitor_pkg::mode_e)
//   D       32       counter load data
//   Q       32       counter value
//   RCO     1        counter ripple-carry output
//   LOAD    8        counter load indication
//
// Modports:
//   master - the side that drives the counter controls and outputs
//   slave  - an observer (the monitor); all signals are inputs
//-----------------------------------------------------------------------------
interface counter_monitor_if;
  import counter_monitor_pkg::*;

  logic              ENABLE;
  logic [1:0]        MODO;
  logic [CNT_W-1:0]  D;
  logic [CNT_W-1:0]  Q;
  logic              RCO;
  logic [LOAD_W-1:0] LOAD;

  modport master (
    output ENABLE,
    output MODO,
    output D,
    output Q,
    output RCO,
    output LOAD
  );

  modport slave (
    input ENABLE,
    input MODO,
    input D,
    input Q,
    input RCO,
    input LOAD
  );

endinterface : counter_monitor_if

// File: rtl/counter_predict.sv
//-----------------------------------------------------------------------------
// counter_predict
//
// Purely combinational model of the counter's next-cycle outputs, given the
// previous cycle's sample of its controls and value. All arithmetic is
// modulo 2^32.
//
// Ports:
//   p_e       in   1   previous ENABLE
//   p_m       in   2   previous MODO
//   p_d       in   32  previous D
//   p_q       in   32  previous Q
//   exp_q     out  32  expected Q this cycle
//   exp_rco   out  1   expected RCO this cycle
//   exp_load  out  8   expected LOAD this cycle
//-----------------------------------------------------------------------------
module counter_predict
  import counter_monitor_pkg::*;
(
  input  logic              p_e,
  input  mode_e             p_m,
  input  logic [CNT_W-1:0]  p_d,
  input  logic [CNT_W-1:0]  p_q,
  output logic [CNT_W-1:0]  exp_q,
  output logic              exp_rco,
  output logic [LOAD_W-1:0] exp_load
);

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path through
    // the block leaves one unassigned and no latch is inferred.
    exp_q    = p_q;
    exp_rco  = 1'b0;
    exp_load = LOAD_OFF;

    if (p_e) begin
      case (p_m)
        COUNT_UP: begin
          exp_q   = p_q + CNT_W'(1);
          exp_rco = (p_q == '1);
        end
        COUNT_DOWN: begin
          exp_q   = p_q - CNT_W'(1);
          exp_rco = (p_q == '0);
        end
        COUNT_3_DOWN: begin
          // Carry out whenever the subtraction of 3 wraps below zero.
          exp_q   = p_q - CNT_W'(3);
          exp_rco = (p_q < CNT_W'(3));
        end
        CHARGE: begin
          exp_q    = p_d;
          exp_load = LOAD_ON;
        end
        default: begin
          exp_q = p_q;
        end
      endcase
    end
  end

endmodule : counter_predict

// File: rtl/counter_monitor.sv
//-----------------------------------------------------------------------------
// counter_monitor
//
// Cycle-accurate checker for the 32-bit up/down/load counter. Every cycle it
// samples the counter controls and value, predicts what the counter must
// show one cycle later, and compares. A mismatch raises ERR for one cycle
// (registered, so it appears one clk after the offending inputs), bumps a
// saturating error counter, and the first mismatch after reset has its
// expected/observed Q captured.
//
// After reset the FSM walks IDLE -> PRIME -> CHECK: IDLE collects the first
// sample, PRIME holds off one more cycle, and only CHECK compares. A reset
// throws away the pending prediction.
//
// Build option:
//   COUNTER_MON_FLAGS_EN  defined: RCO and LOAD are compared as well as Q.
//                         undefined: only Q is compared; RCO/LOAD ignored.
//
// Parameters:
//   ERR_CNT_W  width of the saturating error counter (default 16)
//
// Ports:
//   clk        in   1          clock, rising edge
//   RESET      in   1          synchronous, active-high reset
//   bus        slave modport of counter_monitor_if (counter under check)
//   ERR        out  1          one-cycle pulse per mismatching cycle
//   ERR_CNT    out  ERR_CNT_W  saturating mismatch count
//   CHK_CNT    out  32         number of compared cycles, wraps
//   FIRST_EXP  out  32         expected Q at the first mismatch
//   FIRST_GOT  out  32         observed Q at the first mismatch
//   LOCKED     out  1          high while in CHECK
//-----------------------------------------------------------------------------
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 RESET,
  counter_monitor_if.slave     bus,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0]     CHK_CNT,
  output logic [CNT_W-1:0]     FIRST_EXP,
  output logic [CNT_W-1:0]     FIRST_GOT,
  output logic                 LOCKED
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  sample_t           prev;

  logic [CNT_W-1:0]  exp_q;
  logic              exp_rco;
  logic [LOAD_W-1:0] exp_load;

  logic              cmp_active;
  logic              mismatch;
  logic              err_hit;

  //---------------------------------------------------------------------------
  // Prediction from last cycle's sample
  //---------------------------------------------------------------------------
  counter_predict u_predict (
    .p_e      (prev.en),
    .p_m      (prev.mode),
    .p_d      (prev.d),
    .p_q      (prev.q),
    .exp_q    (exp_q),
    .exp_rco  (exp_rco),
    .exp_load (exp_load)
  );

  //---------------------------------------------------------------------------
  // Comparison. Several fields disagreeing in one cycle still make a single
  // mismatch, so they are OR-ed into one bit.
  //---------------------------------------------------------------------------
`ifdef COUNTER_MON_FLAGS_EN
  assign mismatch = (bus.Q != exp_q) || (bus.RCO != exp_rco) ||
                    (bus.LOAD != exp_load);
`else
  assign mismatch = (bus.Q != exp_q);

  // Flag inputs and flag predictions are deliberately left unchecked.
  logic unused_flags;
  assign unused_flags = ^{bus.RCO, bus.LOAD, exp_rco, exp_load};
`endif

  assign cmp_active = (state == ST_CHECK);
  assign err_hit    = cmp_active && mismatch;
  assign LOCKED     = cmp_active;

  //---------------------------------------------------------------------------
  // FSM next state
  //---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_PRIME;
      ST_PRIME: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_CHECK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  //---------------------------------------------------------------------------
  // State, sample and result registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= ST_IDLE;
      prev      <= SAMPLE_RST;
      ERR       <= 1'b0;
      ERR_CNT   <= '0;
      CHK_CNT   <= '0;
      FIRST_EXP <= '0;
      FIRST_GOT <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values of the others regardless of statement order.
      state     <= state_nxt;
      prev.en   <= bus.ENABLE;
      prev.mode <= mode_e'(bus.MODO);
      prev.d    <= bus.D;
      prev.q    <= bus.Q;
      ERR       <= err_hit;

      if (cmp_active) begin
        CHK_CNT <= CHK_CNT + CNT_W'(1);
      end

      if (err_hit && (ERR_CNT != '1)) begin
        ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
      end

      // ERR_CNT only leaves zero on a mismatch and never returns to zero
      // before the next reset, so zero marks "no mismatch seen yet".
      if (err_hit && (ERR_CNT == '0)) begin
        FIRST_EXP <= exp_q;
        FIRST_GOT <= bus.Q;
      end
    end
  end

endmodule : counter_monitor

// File: tb/tb_counter_monitor.sv
//-----------------------------------------------------------------------------
// tb_counter_monitor
//
// Directed bench for counter_monitor. The bench plays the counter: each step
// drives ENABLE/MODO/D together with the Q/RCO/LOAD a correct (or
// deliberately broken) counter would show in that cycle, then checks the
// monitor outputs 1 time unit after the rising edge that consumed them.
// A second monitor with ERR_CNT_W=2 watches the same bus for saturation.
//-----------------------------------------------------------------------------
module tb_counter_monitor;
  import counter_monitor_pkg::*;

  logic        clk;
  logic        RESET;

  logic        err;
  logic [15:0] err_cnt;
  logic [31:0] chk_cnt;
  logic [31:0] first_exp;
  logic [31:0] first_got;
  logic        locked;

  logic        err_w2;
  logic [1:0]  err_cnt_w2;
  logic [31:0] chk_cnt_w2;
  logic [31:0] first_exp_w2;
  logic [31:0] first_got_w2;
  logic        locked_w2;

  int n_tests = 0;
  int n_fail  = 0;

  counter_monitor_if bus ();

  counter_monitor #(.ERR_CNT_W(16)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .bus       (bus),
    .ERR       (err),
    .ERR_CNT   (err_cnt),
    .CHK_CNT   (chk_cnt),
    .FIRST_EXP (first_exp),
    .FIRST_GOT (first_got),
    .LOCKED    (locked)
  );

  counter_monitor #(.ERR_CNT_W(2)) dut_w2 (
    .clk       (clk),
    .RESET     (RESET),
    .bus       (bus),
    .ERR       (err_w2),
    .ERR_CNT   (err_cnt_w2),
    .CHK_CNT   (chk_cnt_w2),
    .FIRST_EXP (first_exp_w2),
    .FIRST_GOT (first_got_w2),
    .LOCKED    (locked_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of counter activity and step past the rising edge.
  task automatic cyc(input logic en, input logic [1:0] m,
                     input logic [31:0] d, input logic [31:0] q,
                     input logic rco, input logic [7:0] ld);
    bus.ENABLE = en;
    bus.MODO   = m;
    bus.D      = d;
    bus.Q      = q;
    bus.RCO    = rco;
    bus.LOAD   = ld;
    @(posedge clk);
    #1;
  endtask

  int   e_cnt;
  logic e_err;

  initial begin
    // ---------------- reset state ----------------
    RESET = 1'b1;
    cyc(0, 2'b00, 0, 0, 0, 8'h00);
    check("rst_err",       err,        0);
    check("rst_err_cnt",   err_cnt,    0);
    check("rst_chk_cnt",   chk_cnt,    0);
    check("rst_first_exp", first_exp,  0);
    check("rst_first_got", first_got,  0);
    check("rst_locked",    locked,     0);
    check("rst_w2_errcnt", err_cnt_w2, 0);
    RESET = 1'b0;

    // ---------------- load 0x10 then count up to 0x15 ----------------
    cyc(0, 2'b00, 0, 0, 0, 8'h00);                 // IDLE
    check("s1_locked_prime", locked, 0);
    cyc(1, 2'b11, 32'h10, 0, 0, 8'h00);            // PRIME, request load
    check("s1_locked_check", locked, 1);
    check("s1_chk_cnt0",     chk_cnt, 0);
    cyc(1, 2'b00, 0, 32'h10, 0, 8'hFF);            // load visible
    check("s1_err_load", err, 0);
    check("s1_chk_cnt1", chk_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 2'b00, 0, 32'h10 + i, 0, 8'h00);
      check("s1_err_up", err, 0);
    end
    cyc(0, 2'b00, 0, 32'h15, 0, 8'h00);
    check("s1_err_last", err,     0);
    check("s1_chk_cnt6", chk_cnt, 6);
    check("s1_err_cnt",  err_cnt, 0);

    // ---------------- up-count wrap with RCO ----------------
    cyc(1, 2'b11, 32'hFFFF_FFFE, 32'h15, 0, 8'h00);
    check("s2_err_a", err, 0);
    cyc(1, 2'b00, 0, 32'hFFFF_FFFE, 0, 8'hFF);
    check("s2_err_b", err, 0);
    cyc(1, 2'b00, 0, 32'hFFFF_FFFF, 0, 8'h00);
    check("s2_err_c", err, 0);
    cyc(0, 2'b00, 0, 32'h0, 1, 8'h00);             // wrapped, carry out
    check("s2_err_wrap", err,     0);
    check("s2_chk_cnt",  chk_cnt, 10);

    // ---------------- down-by-3 from 2, Q forced wrong ----------------
    cyc(1, 2'b11, 32'h2, 32'h0, 0, 8'h00);
    check("s3_err_a", err, 0);
    cyc(1, 2'b10, 0, 32'h2, 0, 8'hFF);
    check("s3_err_b", err, 0);
    cyc(0, 2'b00, 0, 32'h0, 1, 8'h00);             // expected 0xFFFFFFFF
    check("s3_err_pulse", err,       1);
    check("s3_err_cnt",   err_cnt,   1);
    check("s3_first_exp", first_exp, 32'hFFFF_FFFF);
    check("s3_first_got", first_got, 32'h0);
    cyc(0, 2'b00, 0, 32'h0, 0, 8'h00);
    check("s3_err_drop",  err,     0);
    check("s3_err_cnt_h", err_cnt, 1);

    // ---------------- flags wrong, Q right ----------------
`ifdef COUNTER_MON_FLAGS_EN
    e_err = 1'b1;
    e_cnt = 2;
`else
    e_err = 1'b0;
    e_cnt = 1;
`endif
    cyc(0, 2'b00, 0, 32'h0, 1, 8'h5A);
    check("flag_err",       err,       e_err);
    check("flag_err_cnt",   err_cnt,   e_cnt);
    check("flag_first_exp", first_exp, 32'hFFFF_FFFF);

    // ---------------- disabled counter holds 0x1234 ----------------
    cyc(1, 2'b11, 32'h1234, 32'h0, 0, 8'h00);
    check("s4_err_load", err, 0);
    cyc(0, 2'b00, 0, 32'h1234, 0, 8'hFF);
    check("s4_err_hold0", err, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b00, 0, 32'h1234, 0, 8'h00);
      check("s4_err_hold", err, 0);
    end
    cyc(0, 2'b00, 0, 32'h1235, 0, 8'h00);          // moved while disabled
    e_cnt++;
    check("s4_err_pulse",   err,       1);
    check("s4_err_cnt",     err_cnt,   e_cnt);
    check("s4_first_got",   first_got, 32'h0);

    // ---------------- reset mid-count with corrupted Q ----------------
    cyc(1, 2'b00, 0, 32'h1235, 0, 8'h00);
    check("s6_err_a", err, 0);
    cyc(1, 2'b00, 0, 32'h1236, 0, 8'h00);
    check("s6_err_b", err, 0);
    RESET = 1'b1;
    cyc(1, 2'b00, 0, 32'hDEAD, 0, 8'h00);          // expected 0x1237
    RESET = 1'b0;
    check("s6_err_rst",       err,       0);
    check("s6_locked_rst",    locked,    0);
    check("s6_err_cnt_rst",   err_cnt,   0);
    check("s6_chk_cnt_rst",   chk_cnt,   0);
    check("s6_first_exp_rst", first_exp, 0);
    cyc(1, 2'b00, 0, 32'h100, 0, 8'h00);           // IDLE: no compare
    check("s6_err_idle",    err,     0);
    check("s6_locked_idle", locked,  0);
    cyc(1, 2'b00, 0, 32'h555, 0, 8'h00);           // PRIME: no compare
    check("s6_err_prime",    err,     0);
    check("s6_locked_prime", locked,  1);
    check("s6_chk_cnt_pr",   chk_cnt, 0);
    cyc(1, 2'b00, 0, 32'h556, 0, 8'h00);           // first compare
    check("s6_err_resume", err,     0);
    check("s6_chk_cnt1",   chk_cnt, 1);

    // ---------------- five consecutive mismatches ----------------
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b00, 0, 32'h560 + i, 0, 8'h00);
      check("s5_err",        err,        1);
      check("s5_err_w2",     err_w2,     1);
      check("s5_err_cnt",    err_cnt,    i + 1);
      check("s5_err_cnt_w2", err_cnt_w2, (i + 1 > 3) ? 3 : i + 1);
    end
    check("s5_first_exp",    first_exp,    32'h557);
    check("s5_first_got",    first_got,    32'h560);
    check("s5_first_exp_w2", first_exp_w2, 32'h557);
    check("s5_first_got_w2", first_got_w2, 32'h560);
    cyc(0, 2'b00, 0, 32'h564, 0, 8'h00);
    check("s5_err_end",    err,        0);
    check("s5_err_cnt_w2", err_cnt_w2, 3);
    check("s5_chk_cnt",    chk_cnt,    7);

    // ---------------- count down by 1 and by 3 ----------------
    cyc(1, 2'b01, 0, 32'h564, 0, 8'h00);
    check("dn_err_a", err, 0);
    cyc(1, 2'b10, 0, 32'h563, 0, 8'h00);
    check("dn_err_b", err, 0);
    cyc(0, 2'b00, 0, 32'h560, 0, 8'h00);
    check("dn3_err", err, 0);
    check("dn_err_cnt", err_cnt, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_monitor
